// File: rtl/byte_receiver.sv
// byte_receiver: serial-to-parallel receiver with a double-buffered valid/ready output.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   enable    sample `in` on this edge
//   in        serial data bit
//   clear     synchronous abort of the partial word; also clears overrun
//   ready     consumer accepts data_out when valid && ready
//   data_out  last completed word
//   valid     data_out holds an unconsumed word
//   overrun   sticky flag: a completed word was dropped
//   bit_count bits currently held in the shift register (0..WIDTH-1)
module byte_receiver #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned CW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in,
    input  logic             clear,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             overrun,
    output logic [CW-1:0]    bit_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word_c;
    logic             complete_c;
    logic             load_c;
    logic             drop_c;

    // Shift-register image after this edge's sample; also the completed word.
    always_comb begin
        word_c = sr;
        if (MSB_FIRST) begin
            word_c = {sr[WIDTH-2:0], in};
        end else begin
            word_c = {in, sr[WIDTH-1:1]};
        end
    end

    // clear overrides enable, so a concurrent last bit never completes a word.
    assign complete_c = enable && !clear && (bit_count == CW'(WIDTH - 1));

    // Shift register and bit counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr        <= '0;
            bit_count <= '0;
        end else if (clear) begin
            sr        <= '0;
            bit_count <= '0;
        end else if (enable) begin
            sr        <= word_c;
            bit_count <= complete_c ? '0 : bit_count + CW'(1);
        end
    end

    // Output buffer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a completion keeps or makes the buffer full.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (complete_c) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (!complete_c && ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Output decode: load the new word when the buffer is free or being drained.
    always_comb begin
        load_c = 1'b0;
        drop_c = 1'b0;
        case (state)
            EMPTY: load_c = complete_c;
            FULL: begin
                load_c = complete_c && ready;
                drop_c = complete_c && !ready;
            end
            default: begin
                load_c = 1'b0;
                drop_c = 1'b0;
            end
        endcase
    end

    // Held word and sticky overrun flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
            overrun  <= 1'b0;
        end else begin
            if (load_c) begin
                data_out <= word_c;
            end
            if (clear) begin
                overrun <= 1'b0;
            end else if (drop_c) begin
                overrun <= 1'b1;
            end
        end
    end

    assign valid = (state == FULL);

endmodule

// File: tb/tb_byte_receiver.sv
// Self-checking bench for byte_receiver: one MSB-first and one LSB-first
// instance share all stimulus; expected words flow through scoreboard queues.
module tb_byte_receiver;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             in;
    logic             clear;
    logic             ready;
    logic [WIDTH-1:0] data_m, data_l;
    logic             valid_m, valid_l;
    logic             overrun_m, overrun_l;
    logic [CW-1:0]    count_m, count_l;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] exp_m[$];
    logic [WIDTH-1:0] exp_l[$];

    always #5 clk = ~clk;

    byte_receiver #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .enable(enable), .in(in), .clear(clear),
        .ready(ready), .data_out(data_m), .valid(valid_m), .overrun(overrun_m),
        .bit_count(count_m)
    );

    byte_receiver #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .enable(enable), .in(in), .clear(clear),
        .ready(ready), .data_out(data_l), .valid(valid_l), .overrun(overrun_l),
        .bit_count(count_l)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs on the falling edge, return just after the next rising edge.
    task automatic step(input logic en, input logic b, input logic clr);
        @(negedge clk);
        enable = en;
        in     = b;
        clear  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit lsb, input bit gap,
                             input bit ready_on_last);
        for (int i = 0; i < 32; i++) begin
            if (gap && i != 0) step(1'b0, 1'b0, 1'b0);
            if (ready_on_last && i == 31) ready = 1'b1;
            step(1'b1, lsb ? w[i] : w[31 - i], 1'b0);
        end
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        in     = 1'b0;
        clear  = 1'b0;
        ready  = 1'b0;
        #12;
        check("reset valid", 64'(valid_m), 64'd0);
        check("reset count", 64'(count_m), 64'd0);
        check("reset data", 64'(data_m), 64'd0);
        check("reset overrun", 64'(overrun_m), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Basic MSB-first word, consumer always ready
        ready = 1'b1;
        exp_m.push_back(32'hDEADBEEF);
        send_word(32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        check("basic valid", 64'(valid_m), 64'd1);
        check("basic data", 64'(data_m), 64'(exp_m.pop_front()));
        check("basic count", 64'(count_m), 64'd0);
        check("basic overrun", 64'(overrun_m), 64'd0);
        step(1'b0, 1'b0, 1'b0);
        check("basic drain", 64'(valid_m), 64'd0);

        // Gapped enable, MSB-first
        exp_m.push_back(32'hDEADBEEF);
        send_word(32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        check("gap valid", 64'(valid_m), 64'd1);
        check("gap data", 64'(data_m), 64'(exp_m.pop_front()));
        step(1'b0, 1'b0, 1'b0);

        // LSB-first instance, bit 0 sent first
        exp_l.push_back(32'hDEADBEEF);
        send_word(32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        check("lsb valid", 64'(valid_l), 64'd1);
        check("lsb data", 64'(data_l), 64'(exp_l.pop_front()));
        step(1'b0, 1'b0, 1'b0);
        check("lsb drain", 64'(valid_l), 64'd0);

        // Back-pressure: second word is dropped
        ready = 1'b0;
        exp_m.push_back(32'h12345678);
        send_word(32'h12345678, 1'b0, 1'b0, 1'b0);
        check("bp first valid", 64'(valid_m), 64'd1);
        check("bp first overrun", 64'(overrun_m), 64'd0);
        send_word(32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
        check("bp data held", 64'(data_m), 64'(exp_m.pop_front()));
        check("bp valid", 64'(valid_m), 64'd1);
        check("bp overrun", 64'(overrun_m), 64'd1);
        step(1'b0, 1'b0, 1'b1);
        check("clear overrun", 64'(overrun_m), 64'd0);
        check("clear keeps valid", 64'(valid_m), 64'd1);
        ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("bp drain", 64'(valid_m), 64'd0);

        // Accept and completion on the same edge
        ready = 1'b0;
        send_word(32'h11111111, 1'b0, 1'b0, 1'b0);
        check("hold valid", 64'(valid_m), 64'd1);
        exp_m.push_back(32'h22222222);
        send_word(32'h22222222, 1'b0, 1'b0, 1'b1);
        check("simul data", 64'(data_m), 64'(exp_m.pop_front()));
        check("simul valid", 64'(valid_m), 64'd1);
        check("simul overrun", 64'(overrun_m), 64'd0);
        step(1'b0, 1'b0, 1'b0);
        check("simul drain", 64'(valid_m), 64'd0);

        // Clear mid-word overrides a concurrent sample
        for (int i = 0; i < 10; i++) step(1'b1, 1'(i % 2), 1'b0);
        check("partial count", 64'(count_m), 64'd10);
        step(1'b1, 1'b1, 1'b1);
        check("clear count", 64'(count_m), 64'd0);
        check("clear no word", 64'(valid_m), 64'd0);
        exp_m.push_back(32'hA5A5A5A5);
        send_word(32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
        check("after clear data", 64'(data_m), 64'(exp_m.pop_front()));
        check("after clear valid", 64'(valid_m), 64'd1);
        step(1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-word with a held word
        ready = 1'b0;
        send_word(32'h3C3C3C3C, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b0);
        check("pre-reset count", 64'(count_m), 64'd17);
        check("pre-reset valid", 64'(valid_m), 64'd1);
        @(negedge clk);
        enable = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async count", 64'(count_m), 64'd0);
        check("async valid", 64'(valid_m), 64'd0);
        check("async data", 64'(data_m), 64'd0);
        check("async overrun", 64'(overrun_m), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        ready = 1'b1;
        exp_m.push_back(32'h0F1E2D3C);
        send_word(32'h0F1E2D3C, 1'b0, 1'b0, 1'b0);
        check("post-reset data", 64'(data_m), 64'(exp_m.pop_front()));
        check("post-reset valid", 64'(valid_m), 64'd1);
        check("post-reset overrun", 64'(overrun_m), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
